// File: rtl/pmc_pm_responder.sv
// pmc_pm_responder: pixel-matrix stand-in driven by the PMC control lines.
// Emulates a config shift chain, saturating per-pixel hit counters and a serial readout chain.
module pmc_pm_responder #(
    parameter int PIXELS    = 16,
    parameter int CNT_WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        pm_res,
    input  logic              pm_store,
    input  logic              pm_strobe,
    input  logic              pm_gate,
    input  logic              pm_sh_b,
    input  logic              pm_sh_a,
    input  logic              pm_clk_sh,
    input  logic              din,
    output logic              dout,
    output logic [PIXELS-1:0] cfg
);
    localparam int L = PIXELS * CNT_WIDTH;
    localparam int RES = 0, STORE = 1, STB = 2, GATE = 3, SHB = 4, SHA = 5, CSH = 6, DIN = 7;

    logic [7:0]           raw, s1, s2;
    logic                 sh_ev, st_ev, stb_ev;
    logic [1:0]           mode;
    logic [PIXELS-1:0]    sr;
    logic [L-1:0]         rd, cnt_flat;
    logic [CNT_WIDTH-1:0] cnt [PIXELS];
    logic                 unused_res;

    assign unused_res = ^pm_res[9:1];
    assign raw  = {din, pm_clk_sh, pm_sh_a, pm_sh_b, pm_gate, pm_strobe, pm_store, pm_res[0]};
    assign mode = {s1[SHB], s1[SHA]};
    assign dout = (mode == 2'b01) ? sr[PIXELS-1] : (mode == 2'b10) ? rd[L-1] : 1'b0;

    // pixel PIXELS-1 lands in the MSBs of the readout chain
    always_comb begin
        cnt_flat = '0;
        for (int i = 0; i < PIXELS; i++)
            cnt_flat[i*CNT_WIDTH +: CNT_WIDTH] = cnt[i];
    end

    // edges are registered so every action commits two clocks after the input rises
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1     <= '0;
            s2     <= '0;
            sh_ev  <= 1'b0;
            st_ev  <= 1'b0;
            stb_ev <= 1'b0;
            sr     <= '0;
            rd     <= '0;
            cfg    <= '0;
        end else begin
            s1     <= raw;
            s2     <= s1;
            sh_ev  <= s1[CSH] & ~s2[CSH];
            st_ev  <= s1[STORE] & ~s2[STORE];
            stb_ev <= s1[STB] & ~s2[STB];
            if (sh_ev && mode == 2'b01)
                sr <= {sr[PIXELS-2:0], s1[DIN]};
            if (sh_ev && mode == 2'b10)
                rd <= {rd[L-2:0], 1'b0};
            else if (sh_ev && mode == 2'b11)
                rd <= cnt_flat;
            if (st_ev)
                cfg <= sr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PIXELS; i++)
                cnt[i] <= '0;
        end else begin
            for (int i = 0; i < PIXELS; i++)
                if (s1[RES])
                    cnt[i] <= '0;
                else if (stb_ev && s1[GATE] && cfg[i] && cnt[i] != {CNT_WIDTH{1'b1}})
                    cnt[i] <= cnt[i] + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end
endmodule

// File: tb/tb_pmc_pm_responder.sv
// tb_pmc_pm_responder: directed self-checking bench for the matrix responder.
module tb_pmc_pm_responder;
    localparam int PIXELS = 16;
    localparam int CNT_WIDTH = 8;
    localparam int L = PIXELS * CNT_WIDTH;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [9:0]        pm_res = '0;
    logic              pm_store = 1'b0, pm_strobe = 1'b0, pm_gate = 1'b0;
    logic              pm_sh_b = 1'b0, pm_sh_a = 1'b0, pm_clk_sh = 1'b0, din = 1'b0;
    logic              dout;
    logic [PIXELS-1:0] cfg;
    int                tests = 0, fails = 0;

    pmc_pm_responder #(.PIXELS(PIXELS), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk(clk), .rst(rst), .pm_res(pm_res), .pm_store(pm_store), .pm_strobe(pm_strobe),
        .pm_gate(pm_gate), .pm_sh_b(pm_sh_b), .pm_sh_a(pm_sh_a), .pm_clk_sh(pm_clk_sh),
        .din(din), .dout(dout), .cfg(cfg)
    );

    always #5 clk = ~clk;

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_mode(input logic [1:0] m);
        @(negedge clk);
        {pm_sh_b, pm_sh_a} = m;
        wait_n(3);
    endtask

    task automatic pulse_sh();
        @(negedge clk);
        pm_clk_sh = 1'b1;
        wait_n(3);
        pm_clk_sh = 1'b0;
        wait_n(3);
    endtask

    task automatic pulse_strobe();
        @(negedge clk);
        pm_strobe = 1'b1;
        wait_n(3);
        pm_strobe = 1'b0;
        wait_n(3);
    endtask

    task automatic pulse_store();
        @(negedge clk);
        pm_store = 1'b1;
        wait_n(3);
        pm_store = 1'b0;
        wait_n(3);
    endtask

    task automatic shift_word(input logic [15:0] v);
        set_mode(2'b01);
        for (int b = 15; b >= 0; b--) begin
            @(negedge clk);
            din = v[b];
            pulse_sh();
        end
    endtask

    task automatic readout(output logic [L-1:0] v);
        set_mode(2'b11);
        pulse_sh();
        set_mode(2'b10);
        v = '0;
        for (int k = 0; k < L; k++) begin
            @(negedge clk);
            v[L-1-k] = dout;
            pulse_sh();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pm_res = '1; pm_store = 1; pm_strobe = 1; pm_gate = 1;
        pm_sh_b = 1; pm_sh_a = 1; pm_clk_sh = 1; din = 1;
        wait_n(3);
        tests++; if (dout !== 1'b0) begin fails++; $display("FAIL reset_dout got %b want 0", dout); end
        tests++; if (cfg !== 16'h0) begin fails++; $display("FAIL reset_cfg got %h want 0000", cfg); end
        rst = 1'b0;
        wait_n(6);
        tests++; if (cfg !== 16'h0) begin fails++; $display("FAIL release_cfg got %h want 0000", cfg); end
        pm_res = '0; pm_store = 0; pm_strobe = 0; pm_gate = 0;
        pm_sh_b = 0; pm_sh_a = 0; pm_clk_sh = 0; din = 0;
        wait_n(4);
        pulse_sh();
        tests++; if (cfg !== 16'h0) begin fails++; $display("FAIL mode00_cfg got %h want 0000", cfg); end
        set_mode(2'b01);
        tests++; if (dout !== 1'b0) begin fails++; $display("FAIL mode00_sr got %b want 0", dout); end
    endtask

    task automatic test_config();
        shift_word(16'hA5C3);
        tests++; if (cfg !== 16'h0) begin fails++; $display("FAIL cfg_before_store got %h want 0000", cfg); end
        tests++; if (dout !== 1'b1) begin fails++; $display("FAIL sr_msb got %b want 1", dout); end
        @(negedge clk);
        din = 1'b0; pm_clk_sh = 1'b1; pm_store = 1'b1;
        wait_n(3);
        pm_clk_sh = 1'b0; pm_store = 1'b0;
        wait_n(3);
        tests++; if (cfg !== 16'hA5C3) begin fails++; $display("FAIL store_with_shift got %h want a5c3", cfg); end
        tests++; if (dout !== 1'b0) begin fails++; $display("FAIL sr_after_17th got %b want 0", dout); end
    endtask

    task automatic test_latency();
        @(negedge clk);
        din = 1'b0; pm_clk_sh = 1'b1;
        @(posedge clk); #1;
        tests++; if (dout !== 1'b0) begin fails++; $display("FAIL lat_edge_n got %b want 0", dout); end
        @(posedge clk); #1;
        tests++; if (dout !== 1'b0) begin fails++; $display("FAIL lat_edge_n1 got %b want 0", dout); end
        @(posedge clk); #1;
        tests++; if (dout !== 1'b1) begin fails++; $display("FAIL lat_edge_n2 got %b want 1", dout); end
        repeat (10) @(posedge clk);
        #1;
        tests++; if (dout !== 1'b1) begin fails++; $display("FAIL held_single_shift got %b want 1", dout); end
        @(negedge clk);
        pm_clk_sh = 1'b0;
        wait_n(3);
    endtask

    task automatic test_counting();
        logic [L-1:0] v;
        shift_word(16'h0003);
        pulse_store();
        tests++; if (cfg !== 16'h0003) begin fails++; $display("FAIL cfg_0003 got %h want 0003", cfg); end
        @(negedge clk); pm_gate = 1'b1; wait_n(3);
        repeat (5) pulse_strobe();
        @(negedge clk); pm_gate = 1'b0; wait_n(3);
        repeat (3) pulse_strobe();
        readout(v);
        tests++; if (v !== 128'h0505) begin fails++; $display("FAIL readout_count5 got %h want 0505", v); end
        pulse_sh();
        tests++; if (dout !== 1'b0) begin fails++; $display("FAIL readout_extra got %b want 0", dout); end
    endtask

    task automatic test_clear();
        logic [L-1:0] v;
        @(negedge clk);
        pm_gate = 1'b1;
        wait_n(3);
        pm_res[0] = 1'b1; pm_strobe = 1'b1;
        wait_n(3);
        pm_strobe = 1'b0;
        wait_n(3);
        pm_res[0] = 1'b0;
        wait_n(3);
        readout(v);
        tests++; if (v !== '0) begin fails++; $display("FAIL clear_beats_inc got %h want 0", v); end
        pulse_strobe();
        readout(v);
        tests++; if (v !== 128'h0101) begin fails++; $display("FAIL count_after_clear got %h want 0101", v); end
    endtask

    task automatic test_saturation();
        logic [L-1:0] v;
        repeat (300) pulse_strobe();
        readout(v);
        tests++; if (v !== 128'hFFFF) begin fails++; $display("FAIL saturate got %h want ffff", v); end
    endtask

    initial begin
        test_reset();
        test_config();
        test_latency();
        test_counting();
        test_clear();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
